// File: rtl/cacheline_adaptor.sv
// Bridges a 256-bit line request from the cache to a four-beat 64-bit memory burst.
// Beats are sequenced by an IDLE/READ/WRITE/DONE FSM and a 2-bit beat counter.
module cacheline_adaptor #(
  parameter int LINE_WIDTH  = 256,
  parameter int BURST_WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   pmem_read,
  input  logic                   pmem_write,
  input  logic [31:0]            pmem_address,
  input  logic [LINE_WIDTH-1:0]  pmem_wdata,
  output logic [LINE_WIDTH-1:0]  pmem_rdata,
  output logic                   pmem_resp,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic [31:0]            mem_address,
  output logic [BURST_WIDTH-1:0] mem_wdata,
  input  logic [BURST_WIDTH-1:0] mem_rdata,
  input  logic                   mem_resp
);

  localparam int BEATS = LINE_WIDTH / BURST_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [1:0]              cnt_q, cnt_d;
  logic [LINE_WIDTH-1:0]   line_q, line_d;
  logic [LINE_WIDTH-1:0]   rdata_q, rdata_d;
  logic [31:0]             addr_q, addr_d;
  logic                    mem_read_q, mem_read_d;
  logic                    mem_write_q, mem_write_d;
  logic                    last_beat;

  assign last_beat = (cnt_q == 2'(BEATS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      line_q      <= '0;
      rdata_q     <= '0;
      addr_q      <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      line_q      <= line_d;
      rdata_q     <= rdata_d;
      addr_q      <= addr_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
    end
  end

  // line_q is shared between write data and read assembly; rdata_q only
  // updates when a read completes, so write-backs never disturb pmem_rdata.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    line_d      = line_q;
    rdata_d     = rdata_q;
    addr_d      = addr_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    case (state_q)
      S_IDLE: begin
        if (pmem_write) begin
          line_d      = pmem_wdata;
          addr_d      = pmem_address & 32'hFFFF_FFE0;
          cnt_d       = '0;
          mem_write_d = 1'b1;
          state_d     = S_WRITE;
        end else if (pmem_read) begin
          addr_d     = pmem_address & 32'hFFFF_FFE0;
          cnt_d      = '0;
          mem_read_d = 1'b1;
          state_d    = S_READ;
        end
      end
      S_READ: begin
        if (mem_resp) begin
          line_d[BURST_WIDTH*cnt_q +: BURST_WIDTH] = mem_rdata;
          cnt_d = cnt_q + 2'd1;
          if (last_beat) begin
            rdata_d    = {mem_rdata, line_q[LINE_WIDTH-BURST_WIDTH-1:0]};
            mem_read_d = 1'b0;
            state_d    = S_DONE;
          end
        end
      end
      S_WRITE: begin
        if (mem_resp) begin
          cnt_d = cnt_q + 2'd1;
          if (last_beat) begin
            mem_write_d = 1'b0;
            state_d     = S_DONE;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign pmem_resp   = (state_q == S_DONE);
  assign pmem_rdata  = rdata_q;
  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
  assign mem_address = addr_q;
  assign mem_wdata   = (state_q == S_WRITE) ? line_q[BURST_WIDTH*cnt_q +: BURST_WIDTH] : '0;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed bench for cacheline_adaptor: memory beats are driven on the falling edge,
// outputs sampled there too, and each transaction is checked against hand-built lines.
module tb_cacheline_adaptor;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         pmem_read, pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata, pmem_rdata;
  logic         pmem_resp;
  logic         mem_read, mem_write;
  logic [31:0]  mem_address;
  logic [63:0]  mem_wdata, mem_rdata;
  logic         mem_resp;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [255:0] LINE_A = {64'h4444444444444444, 64'h3333333333333333,
                                     64'h2222222222222222, 64'h1111111111111111};
  localparam logic [255:0] LINE_B = {64'h8888888888888888, 64'h7777777777777777,
                                     64'h6666666666666666, 64'h5555555555555555};
  localparam logic [255:0] LINE_C = {64'hDEADBEEF00000003, 64'hDEADBEEF00000002,
                                     64'hDEADBEEF00000001, 64'hDEADBEEF00000000};
  localparam logic [255:0] WLINE  = {64'hDDDDDDDDDDDDDDDD, 64'hCCCCCCCCCCCCCCCC,
                                     64'hBBBBBBBBBBBBBBBB, 64'hAAAAAAAAAAAAAAAA};
  localparam logic [255:0] WLINE2 = {64'hF0F0F0F0F0F0F0F0, 64'h0F0F0F0F0F0F0F0F,
                                     64'h1234567812345678, 64'h8765432187654321};

  cacheline_adaptor dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_address  (mem_address),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_resp     (mem_resp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a falling edge. Acts as cache + memory until pmem_resp is seen,
  // then drops the request and returns at that same falling edge.
  task automatic run_txn(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [255:0] wdata, input logic [255:0] rline,
                         input int gap, output int start_lat, output int lat,
                         output logic saw_read);
    int b = 0;
    int gap_left = gap;
    int edges = 0;
    logic done = 1'b0;
    start_lat = -1;
    lat = -1;
    saw_read = 1'b0;
    pmem_read = rd;
    pmem_write = wr;
    pmem_address = addr;
    pmem_wdata = wdata;
    mem_resp = 1'b0;
    while (!done && edges < 60) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (mem_read) saw_read = 1'b1;
      if ((mem_read || mem_write) && start_lat < 0) begin
        start_lat = edges;
        chk("mem_address", {224'd0, mem_address}, {224'd0, addr & 32'hFFFF_FFE0});
      end
      mem_resp = 1'b0;
      if (pmem_resp) begin
        lat = edges;
        done = 1'b1;
        pmem_read = 1'b0;
        pmem_write = 1'b0;
      end else if ((mem_read || mem_write) && b < 4) begin
        if (b == 2 && gap_left > 0) begin
          gap_left--;
        end else begin
          mem_resp = 1'b1;
          mem_rdata = rline[64*b +: 64];
          if (mem_write) chk($sformatf("wbeat%0d", b), {192'd0, mem_wdata}, {192'd0, wdata[64*b +: 64]});
          b++;
        end
      end
    end
    chk("txn_done", {255'd0, done}, 256'd1);
    pmem_read = 1'b0;
    pmem_write = 1'b0;
    mem_resp = 1'b0;
  endtask

  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("idle_resp", {255'd0, pmem_resp}, 256'd0);
      chk("idle_mem_rw", {254'd0, mem_read, mem_write}, 256'd0);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rw_resp"}, {253'd0, mem_read, mem_write, pmem_resp}, 256'd0);
    chk({tag, "_addr"}, {224'd0, mem_address}, 256'd0);
    chk({tag, "_wdata"}, {192'd0, mem_wdata}, 256'd0);
    chk({tag, "_rdata"}, pmem_rdata, 256'd0);
  endtask

  initial begin
    int s, l;
    logic sr;
    rst_n = 1'b0;
    pmem_read = 1'b0;
    pmem_write = 1'b0;
    pmem_address = '0;
    pmem_wdata = '0;
    mem_rdata = '0;
    mem_resp = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    idle_check(1);

    // read, no gaps
    run_txn(1'b1, 1'b0, 32'h0000_1234, '0, LINE_A, 0, s, l, sr);
    chk("rd_start", 256'(s), 256'd1);
    chk("rd_lat", 256'(l), 256'd5);
    chk("rd_data", pmem_rdata, LINE_A);
    idle_check(2);

    // read with a 3-cycle gap between beats 1 and 2
    run_txn(1'b1, 1'b0, 32'h0000_1234, '0, LINE_A, 3, s, l, sr);
    chk("rdgap_lat", 256'(l), 256'd8);
    chk("rdgap_data", pmem_rdata, LINE_A);
    idle_check(2);

    // write
    run_txn(1'b0, 1'b1, 32'h8000_0047, WLINE, '0, 0, s, l, sr);
    chk("wr_start", 256'(s), 256'd1);
    chk("wr_lat", 256'(l), 256'd5);
    chk("wr_noread", {255'd0, sr}, 256'd0);
    chk("wr_keep_rdata", pmem_rdata, LINE_A);
    idle_check(2);

    // simultaneous read and write: write wins
    run_txn(1'b1, 1'b1, 32'h0000_00FF, WLINE2, LINE_C, 1, s, l, sr);
    chk("both_noread", {255'd0, sr}, 256'd0);
    chk("both_lat", 256'(l), 256'd6);
    chk("both_keep_rdata", pmem_rdata, LINE_A);
    idle_check(2);

    // write-back followed immediately by the refill read
    run_txn(1'b0, 1'b1, 32'h0000_2000, WLINE, '0, 0, s, l, sr);
    chk("wb_lat", 256'(l), 256'd5);
    run_txn(1'b1, 1'b0, 32'h0000_3010, '0, LINE_B, 0, s, l, sr);
    chk("refill_start", 256'(s), 256'd2);
    chk("refill_lat", 256'(l), 256'd6);
    chk("refill_data", pmem_rdata, LINE_B);
    idle_check(2);

    // reset in the middle of a read, after two beats
    pmem_read = 1'b1;
    pmem_address = 32'h0000_4000;
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      mem_resp = 1'b1;
      mem_rdata = LINE_C[64*i +: 64];
      @(posedge clk);
    end
    @(negedge clk);
    mem_resp = 1'b0;
    pmem_read = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk_all_zero("postrst");
    idle_check(4);

    run_txn(1'b1, 1'b0, 32'h0000_4000, '0, LINE_C, 0, s, l, sr);
    chk("after_rst_lat", 256'(l), 256'd5);
    chk("after_rst_data", pmem_rdata, LINE_C);
    idle_check(1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
